dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Data-memory controller directly downstream of the multicycle processor core. Consumes the core's MemRead/MemWrite/dAddress/dWriteData request and returns dReadData through an on-chip word RAM with a programmable wait-state FSM. Reports completion with a one-cycle ready pulse, which the core's memory-access state waits on. Also flags misaligned, out-of-range or conflicting requests.

Parameters:
BASE_ADDR, 32'h10010000, byte address of RAM word 0
DEPTH_WORDS, 1024, number of 32-bit words; power of two
WAIT_STATES, 2, extra stall cycles before the RAM access; 0..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
MemRead  input  1  read request from core
MemWrite  input  1  write request from core
dAddress  input  32  byte address
dWriteData  input  32  store data
dReadData  output  32  load data, registered, valid while mem_ready=1
mem_ready  output  1  one-cycle completion pulse
mem_err  output  1  error flag, valid only while mem_ready=1
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, wait counter=0, dReadData=0, mem_ready=0, mem_err=0, busy=0. RAM contents are not cleared.
- States: IDLE, WAIT, ACCESS, RESP. Encoding is 2 bits.
- IDLE: on a clk edge with MemRead|MemWrite=1, latch the address, write data, op and error code; load counter=WAIT_STATES.
  - If WAIT_STATES=0, go to ACCESS; otherwise go to WAIT.
- WAIT: decrement the counter each edge; move to ACCESS on the edge where counter==1.
- ACCESS: perform the single RAM operation on the edge, register the result, go to RESP.
  - Write: RAM[idx] <= latched data.
  - Read: dReadData <= RAM[idx].
- RESP: mem_ready=1 and busy=1 for exactly one cycle, then IDLE.
  - The core drops its request on the same edge that leaves RESP.
  - A request still high in IDLE starts a new access.
- Latency: with the request first seen at edge N, mem_ready is high in the cycle after edge N+WAIT_STATES+1.
- Index calculation: idx = (dAddress - BASE_ADDR) >> 2 (32-bit unsigned subtraction).
- Error conditions, checked at latch time:
  - misaligned: dAddress[1:0] != 0
  - out of range: dAddress < BASE_ADDR or idx >= DEPTH_WORDS
  - conflict: MemRead & MemWrite
- On error: the FSM still walks WAIT/ACCESS/RESP with the normal latency, no RAM write occurs, dReadData=0, and mem_err=1 alongside mem_ready.
- dReadData holds its last value outside RESP. It is cleared only by reset or an errored read.
- Request inputs changing while busy are ignored; the latched copy is used.
- Reset asserted in WAIT: no write occurs. Reset asserted in ACCESS before the edge: the write is aborted. A write completed at the ACCESS edge persists.
- Reset never produces a mem_ready pulse.

Optional Feature:
Macro: DMEM_SUBWORD_EN
- Defined:
  - Adds input port size[1:0]: 00 byte, 01 half, 10 word, 11 treated as an error.
  - Writes update only the addressed byte lanes (byte lane = dAddress[1:0]; half lane = dAddress[1]).
  - Reads return the selected lane shifted to bit 0 and zero-extended; the core performs sign extension.
  - Alignment is checked per size: a half needs dAddress[0]=0; a byte is always aligned.
  - idx uses dAddress with [1:0] ignored.
- Undefined: no size port; word-only behaviour exactly as above.

Test Plan:
- Reset then idle, no request -> all outputs 0, busy=0; 20 cycles with no mem_ready pulse.
- WAIT_STATES=2: write 32'hDEADBEEF at 32'h10010008, then read the same address -> each op shows mem_ready 4 cycles after the request edge, mem_err=0, read returns 32'hDEADBEEF.
- WAIT_STATES=0: read at 32'h10010004 after writing 32'h00000055 -> mem_ready in the second cycle, data 32'h00000055.
- Error cases, each returning mem_err=1 with mem_ready, no RAM write, and a later read of 32'h10010000 unchanged:
  - misaligned write at 32'h10010002
  - out-of-range write at 32'h10011000 (DEPTH_WORDS=1024)
  - conflicting request with MemRead=MemWrite=1
- rst pulsed low during WAIT of a write of 32'h12345678 to 32'h10010010 -> outputs clear immediately, no mem_ready, and a subsequent read returns the old contents.
- DMEM_SUBWORD_EN: word 32'h11223344 at 32'h10010020, then byte write 8'hAA at 32'h10010021 -> word reads 32'h1122AA44, byte read at 32'h10010023 returns 32'h00000011.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller behind the multicycle core.
// Latches one MemRead/MemWrite request, stalls WAIT_STATES cycles, performs a
// single access to an on-chip word RAM and answers with a one-cycle mem_ready
// pulse. Misaligned, out-of-range and read+write requests are flagged on
// mem_err and never touch the RAM.
// Build option: define DMEM_SUBWORD_EN to add the size[1:0] port for byte and
// halfword accesses; without it every access is a full 32-bit word.
module dmem_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] dAddress,
   input  logic [31:0] dWriteData,
`ifdef DMEM_SUBWORD_EN
   input  logic [1:0]  size,
`endif
   output logic [31:0] dReadData,
   output logic        mem_ready,
   output logic        mem_err,
   output logic        busy
);

   localparam int unsigned AW          = $clog2(DEPTH_WORDS);
   localparam logic [31:0] DEPTH_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic          err_q, err_d;
   logic [1:0]    lane_q, lane_d;   // byte offset of the access inside its word
   logic [1:0]    size_q, size_d;   // 00 byte, 01 half, 10 word
   logic [31:0]   rdata_q, rdata_d;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [1:0]    req_size;
   logic [31:0]   req_offset;
   logic          misaligned, out_of_range;
   logic [31:0]   ram_word, rd_value, wr_value;
   logic [3:0]    ram_be;
   logic          ram_we;

`ifdef DMEM_SUBWORD_EN
   assign req_size = size;
`else
   assign req_size = 2'b10;
`endif

   // Classify the incoming request: word offset from BASE_ADDR and error causes
   always_comb begin
      req_offset   = {dAddress[31:2], 2'b00} - BASE_ADDR;
      out_of_range = (dAddress < BASE_ADDR) || (req_offset >= DEPTH_BYTES);
      case (req_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = dAddress[0];
         2'b10:   misaligned = |dAddress[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   // Lane steering: byte enables and replicated store data, aligned load data
   always_comb begin
      ram_word = mem[idx_q];
      case (size_q)
         2'b00: begin
            ram_be   = 4'b0001 << lane_q;
            wr_value = {4{wdata_q[7:0]}};
            rd_value = {24'h0, ram_word[{lane_q, 3'b000} +: 8]};
         end
         2'b01: begin
            ram_be   = 4'b0011 << {lane_q[1], 1'b0};
            wr_value = {2{wdata_q[15:0]}};
            rd_value = {16'h0, ram_word[{lane_q[1], 4'b0000} +: 16]};
         end
         default: begin
            ram_be   = 4'b1111;
            wr_value = wdata_q;
            rd_value = ram_word;
         end
      endcase
   end

   // FSM next state, request capture and access result
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      err_d   = err_q;
      lane_d  = lane_q;
      size_d  = size_q;
      rdata_d = rdata_q;
      ram_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (MemRead | MemWrite) begin
               idx_d   = req_offset[AW+1:2];
               wdata_d = dWriteData;
               rd_d    = MemRead;
               wr_d    = MemWrite;
               err_d   = misaligned | out_of_range | (MemRead & MemWrite);
               lane_d  = dAddress[1:0];
               size_d  = req_size;
               cnt_d   = WAIT_INIT;
               state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_ACCESS;
         end
         S_ACCESS: begin
            // An errored read returns zero; an errored write leaves RAM and data alone.
            if (err_q) begin
               if (rd_q) rdata_d = '0;
            end else if (wr_q) begin
               ram_we = 1'b1;
            end else begin
               rdata_d = rd_value;
            end
            state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control and data registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         lane_q  <= '0;
         size_q  <= 2'b10;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         lane_q  <= lane_d;
         size_q  <= size_d;
         rdata_q <= rdata_d;
      end
   end

   // RAM write port; the enable comes from the reset-cleared state, so an
   // asserted reset aborts any pending write
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset; contents survive rst and it can map onto block RAM.
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) mem[idx_q][8*b +: 8] <= wr_value[8*b +: 8];
         end
      end
   end

   assign dReadData = rdata_q;
   assign mem_ready = (state_q == S_RESP);
   assign mem_err   = mem_ready & err_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: two controllers (WAIT_STATES 0 and 2) driven with directed and
// random requests, compared against a behavioural memory model.
module tb_dmem_ctrl;

   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam int unsigned DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read     [2];
   logic        mem_write    [2];
   logic [31:0] d_address    [2];
   logic [31:0] d_write_data [2];
`ifdef DMEM_SUBWORD_EN
   logic [1:0]  size         [2];
`endif
   logic [31:0] d_read_data  [2];
   logic        mem_ready    [2];
   logic        mem_err      [2];
   logic        busy         [2];

   int          n_checks = 0;
   int          n_fail   = 0;

   // Reference memory keyed by dut*2048 + word index; last load value per DUT
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] last_rd [2];
   bit          last_ok [2];

   always #5 clk = ~clk;

   dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .MemRead    (mem_read[0]),
      .MemWrite   (mem_write[0]),
      .dAddress   (d_address[0]),
      .dWriteData (d_write_data[0]),
`ifdef DMEM_SUBWORD_EN
      .size       (size[0]),
`endif
      .dReadData  (d_read_data[0]),
      .mem_ready  (mem_ready[0]),
      .mem_err    (mem_err[0]),
      .busy       (busy[0])
   );

   dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut2 (
      .clk        (clk),
      .rst        (rst),
      .MemRead    (mem_read[1]),
      .MemWrite   (mem_write[1]),
      .dAddress   (d_address[1]),
      .dWriteData (d_write_data[1]),
`ifdef DMEM_SUBWORD_EN
      .size       (size[1]),
`endif
      .dReadData  (d_read_data[1]),
      .mem_ready  (mem_ready[1]),
      .mem_err    (mem_err[1]),
      .busy       (busy[1])
   );

   function automatic int ws(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input int d, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wdt, input logic [1:0] sz);
      mem_read[d]     = rd;
      mem_write[d]    = wr;
      d_address[d]    = a;
      d_write_data[d] = wdt;
`ifdef DMEM_SUBWORD_EN
      size[d]         = sz;
`endif
   endtask

   // One complete transaction: model prediction, request, latency, response
   task automatic do_op(input int d, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wdt, input logic [1:0] sz);
      logic        mis, oor, err;
      logic [31:0] idx, word, rv;
      int unsigned key;
      int          lane, cyc;
      bit          known, got, busy_ok;
      // spec rules in plain arithmetic
      lane = int'(a[1:0]);
      case (sz)
         2'd0:    mis = 1'b0;
         2'd1:    mis = a[0];
         2'd2:    mis = (a[1:0] != 2'd0);
         default: mis = 1'b1;
      endcase
      idx  = (a - BASE) >> 2;
      oor  = (a < BASE) || (idx >= DEPTH);
      err  = mis | oor | (rd & wr);
      key  = oor ? 0 : d * 2048 + idx;
      known = 1'b1;
      rv    = '0;
      if (!err && wr) begin
         word = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
         case (sz)
            2'd0:    word[8*lane +: 8]        = wdt[7:0];
            2'd1:    word[16*(lane/2) +: 16]  = wdt[15:0];
            default: word                     = wdt;
         endcase
         ref_mem[key] = word;
      end
      if (rd && !err) begin
         if (ref_mem.exists(key)) begin
            word = ref_mem[key];
            case (sz)
               2'd0:    rv = {24'h0, word[8*lane +: 8]};
               2'd1:    rv = {16'h0, word[16*(lane/2) +: 16]};
               default: rv = word;
            endcase
         end else begin
            known = 1'b0;
         end
      end

      @(negedge clk);
      drive(d, rd, wr, a, wdt, sz);
      @(posedge clk);
      cyc = 0; got = 1'b0; busy_ok = 1'b1;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (mem_ready[d]) got = 1'b1;
         else begin
            if (!busy[d]) busy_ok = 1'b0;
            // changes while busy must be ignored
            drive(d, 1'($urandom), 1'($urandom), $urandom, $urandom, 2'($urandom));
         end
      end
      check("latency", cyc, ws(d) + 2);
      check("busy_in_flight", busy_ok, 1);
      check("busy_resp", busy[d], got);
      check("mem_err", mem_err[d], err);
      if (rd) begin
         if (known) begin
            check("rdata", d_read_data[d], rv);
            last_rd[d] = rv;
            last_ok[d] = 1'b1;
         end else begin
            last_ok[d] = 1'b0;
         end
      end else if (!err && last_ok[d]) begin
         check("rdata_hold", d_read_data[d], last_rd[d]);
      end
      drive(d, 1'b0, 1'b0, '0, '0, 2'd2);
      @(negedge clk);
      check("pulse_end", {mem_ready[d], busy[d]}, 2'b00);
   endtask

   // Reset pulled k cycles into a write on the WAIT_STATES=2 controller
   task automatic reset_mid(input int k, input logic [31:0] a, input logic [31:0] wdt, input bit persists);
      int seen = 0;
      @(negedge clk);
      drive(1, 1'b0, 1'b1, a, wdt, 2'd2);
      @(posedge clk);
      repeat (k) @(negedge clk);
      check("busy_before_rst", busy[1], 1);
      rst = 1'b0;
      #1;
      check("rst_ctrl", {mem_ready[1], mem_err[1], busy[1]}, 3'b000);
      check("rst_rdata", d_read_data[1], 32'h0);
      drive(1, 1'b0, 1'b0, '0, '0, 2'd2);
      last_rd[0] = '0; last_rd[1] = '0;
      last_ok[0] = 1'b1; last_ok[1] = 1'b1;
      if (persists) ref_mem[2048 + ((a - BASE) >> 2)] = wdt;
      @(negedge clk);
      rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (mem_ready[0] || mem_ready[1]) seen++;
      end
      check("rst_no_ready", seen, 0);
      do_op(1, 1'b1, 1'b0, a, '0, 2'd2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      int d, r, op;
      logic [31:0] a;
      logic [1:0]  sz;
      logic        rd, wr;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(i, 1'b0, 1'b0, '0, '0, 2'd2);
         last_rd[i] = '0;
         last_ok[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("reset_ctrl", {mem_ready[i], mem_err[i], busy[i]}, 3'b000);
         check("reset_rdata", d_read_data[i], 32'h0);
      end
      rst = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_ready[0] || mem_ready[1] || busy[0] || busy[1]) seen++;
      end
      check("idle_quiet", seen, 0);

      // preload a 16-word window and the last valid word on both controllers
      for (int i = 0; i < 2; i++) begin
         for (int w = 0; w < 16; w++) do_op(i, 1'b0, 1'b1, BASE + 32'(4 * w), $urandom, 2'd2);
         do_op(i, 1'b0, 1'b1, BASE + 32'h0FFC, $urandom, 2'd2);
      end

      // word write/read at both latencies
      do_op(1, 1'b0, 1'b1, BASE + 32'h8, 32'hDEAD_BEEF, 2'd2);
      do_op(1, 1'b1, 1'b0, BASE + 32'h8, '0, 2'd2);
      do_op(0, 1'b0, 1'b1, BASE + 32'h4, 32'h0000_0055, 2'd2);
      do_op(0, 1'b1, 1'b0, BASE + 32'h4, '0, 2'd2);
      do_op(1, 1'b1, 1'b0, BASE + 32'h0FFC, '0, 2'd2);

      // error cases, then word 0 must be unchanged
      do_op(1, 1'b0, 1'b1, BASE + 32'h2, 32'hBAD0_0001, 2'd2);
      do_op(1, 1'b0, 1'b1, BASE + 32'h1000, 32'hBAD0_0002, 2'd2);
      do_op(1, 1'b1, 1'b1, BASE, 32'hBAD0_0003, 2'd2);
      do_op(1, 1'b1, 1'b0, BASE - 32'h4, '0, 2'd2);
      do_op(1, 1'b1, 1'b0, BASE, '0, 2'd2);

      // reset in WAIT, in ACCESS (both abort) and in RESP (write persists)
      reset_mid(1, BASE + 32'h10, 32'h1234_5678, 1'b0);
      reset_mid(3, BASE + 32'h14, 32'h8765_4321, 1'b0);
      reset_mid(4, BASE + 32'h18, 32'hCAFE_F00D, 1'b1);

`ifdef DMEM_SUBWORD_EN
      do_op(1, 1'b0, 1'b1, BASE + 32'h20, 32'h1122_3344, 2'd2);
      do_op(1, 1'b0, 1'b1, BASE + 32'h21, 32'h0000_00AA, 2'd0);
      do_op(1, 1'b1, 1'b0, BASE + 32'h20, '0, 2'd2);
      do_op(1, 1'b1, 1'b0, BASE + 32'h23, '0, 2'd0);
      do_op(1, 1'b1, 1'b0, BASE + 32'h22, '0, 2'd1);
      do_op(1, 1'b1, 1'b0, BASE + 32'h21, '0, 2'd1);
`endif

      // random traffic
      for (int i = 0; i < 240; i++) begin
         d  = int'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 9));
         sz = 2'd2;
         a  = BASE + 32'(4 * $urandom_range(0, 15));
`ifdef DMEM_SUBWORD_EN
         sz = 2'($urandom_range(0, 3));
         a  = BASE + 32'($urandom_range(0, 63));
`endif
         if (r == 0) a = a + 32'($urandom_range(1, 3));
         else if (r == 1) a = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 4))
                                                          : BASE + 32'h1000 + 32'(4 * $urandom_range(0, 3));
         op = int'($urandom_range(0, 9));
         rd = (op < 5) || (op == 9);
         wr = (op >= 5);
         do_op(d, rd, wr, a, $urandom, sz);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
